// File: rtl/rooth_test_monitor.sv
// rooth_test_monitor: snoops register write-back to produce a pass/fail/timeout verdict and run counters
module rooth_test_monitor #(
  parameter int DATA_WIDTH     = 32,
  parameter int TNUM_REG       = 3,
  parameter int DONE_REG       = 26,
  parameter int PASS_REG       = 27,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  wb_we_i,
  input  logic [4:0]            wb_waddr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i,
  input  logic                  retire_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [DATA_WIDTH-1:0] fail_testnum_o,
  output logic [31:0]           cycle_cnt_o,
  output logic [31:0]           retire_cnt_o
);
  typedef enum logic [2:0] {IDLE, RUN, SETTLE, PASS, FAIL, TIMEOUT} state_t;
  state_t state, state_nx, verdict;
  logic [DATA_WIDTH-1:0] tnum, pass_sh, tnum_nx, pass_nx, fail_tn;
  logic [31:0] settle_cnt, cycle_cnt, retire_cnt;
  logic active, wr_ok, done_trig, settle_end, tmo, start_ok;
  always_comb begin
    active     = state == RUN || state == SETTLE;
    wr_ok      = active && wb_we_i && wb_waddr_i != 5'd0;
    tnum_nx    = wr_ok && wb_waddr_i == 5'(TNUM_REG) ? wb_wdata_i : tnum;
    pass_nx    = wr_ok && wb_waddr_i == 5'(PASS_REG) ? wb_wdata_i : pass_sh;
    done_trig  = state == RUN && wr_ok && wb_waddr_i == 5'(DONE_REG) && wb_wdata_i == DATA_WIDTH'(1);
    settle_end = state == SETTLE && settle_cnt == 32'd0;
    tmo        = active && cycle_cnt == 32'(TIMEOUT_CYCLES - 1);
    start_ok   = !active && start_i;
    verdict    = pass_nx == DATA_WIDTH'(1) ? PASS : FAIL;
    state_nx   = !active ? (start_i ? RUN : state) :
                 done_trig ? SETTLE : settle_end ? verdict : tmo ? TIMEOUT : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tnum       <= '0;
      pass_sh    <= '0;
      fail_tn    <= '0;
      settle_cnt <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      state      <= state_nx;
      tnum       <= start_ok ? '0 : tnum_nx;
      pass_sh    <= start_ok ? '0 : pass_nx;
      cycle_cnt  <= start_ok ? '0 : cycle_cnt + 32'(active && cycle_cnt != '1);
      retire_cnt <= start_ok ? '0 : retire_cnt + 32'(active && retire_i && retire_cnt != '1);
      settle_cnt <= done_trig ? 32'(SETTLE_CYCLES - 1) : settle_cnt - 32'(state == SETTLE && settle_cnt != 32'd0);
      fail_tn    <= start_ok ? '0 :
                    active && (state_nx == FAIL || state_nx == TIMEOUT) ? tnum_nx : fail_tn;
    end
  end
  assign busy_o         = state == RUN || state == SETTLE;
  assign done_o         = state == PASS || state == FAIL || state == TIMEOUT;
  assign pass_o         = state == PASS;
  assign timeout_o      = state == TIMEOUT;
  assign fail_testnum_o = fail_tn;
  assign cycle_cnt_o    = cycle_cnt;
  assign retire_cnt_o   = retire_cnt;
endmodule

// File: tb/tb_rooth_test_monitor.sv
// tb_rooth_test_monitor: directed checks of verdict, timeout, filtering, counters and restart/reset
module tb_rooth_test_monitor;
  logic clk = 0, rst = 1, start_i = 0, wb_we_i = 0, retire_i = 0;
  logic [4:0] wb_waddr_i = 0;
  logic [31:0] wb_wdata_i = 0;
  logic busy, done, pass, tmo, busy1, done1, pass1, tmo1;
  logic [31:0] ftn, ccnt, rcnt, ftn1, ccnt1, rcnt1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  rooth_test_monitor #(.TIMEOUT_CYCLES(20)) u0 (
    .clk(clk), .rst(rst), .start_i(start_i), .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i),
    .wb_wdata_i(wb_wdata_i), .retire_i(retire_i), .busy_o(busy), .done_o(done), .pass_o(pass),
    .timeout_o(tmo), .fail_testnum_o(ftn), .cycle_cnt_o(ccnt), .retire_cnt_o(rcnt));
  rooth_test_monitor #(.TIMEOUT_CYCLES(20), .DONE_REG(0)) u1 (
    .clk(clk), .rst(rst), .start_i(start_i), .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i),
    .wb_wdata_i(wb_wdata_i), .retire_i(retire_i), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .timeout_o(tmo1), .fail_testnum_o(ftn1), .cycle_cnt_o(ccnt1), .retire_cnt_o(rcnt1));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_we_i = 1;
    wb_waddr_i = a;
    wb_wdata_i = d;
    step();
    wb_we_i = 0;
  endtask
  task automatic go();
    start_i = 1;
    step();
    start_i = 0;
  endtask
  initial begin
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cycle", ccnt, 0);
    chk("rst_ftn", ftn, 0);
    rst = 0;
    step();
    chk("idle_done", done, 0);
    go();
    chk("start_busy", busy, 1);
    chk("start_cycle", ccnt, 0);
    wr(3, 5);
    wr(27, 1);
    wr(26, 1);
    chk("settle_busy", busy, 1);
    chk("settle_done", done, 0);
    step();
    chk("pass_done", done, 1);
    chk("pass_pass", pass, 1);
    chk("pass_ftn", ftn, 0);
    chk("pass_cycle", ccnt, 4);
    go();
    wr(3, 7);
    wr(27, 0);
    wr(26, 1);
    step();
    chk("fail_done", done, 1);
    chk("fail_pass", pass, 0);
    chk("fail_ftn", ftn, 7);
    chk("fail_tmo", tmo, 0);
    go();
    wr(26, 1);
    wr(27, 1);
    chk("late1_pass", pass, 1);
    go();
    wr(26, 1);
    step();
    wr(27, 1);
    chk("late2_done", done, 1);
    chk("late2_pass", pass, 0);
    chk("late2_ftn", ftn, 0);
    go();
    wr(3, 9);
    repeat (18) step();
    chk("pre_tmo_cycle", ccnt, 19);
    chk("pre_tmo_busy", busy, 1);
    step();
    chk("tmo_tmo", tmo, 1);
    chk("tmo_done", done, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_cycle", ccnt, 20);
    chk("tmo_ftn", ftn, 9);
    go();
    repeat (19) step();
    wr(26, 1);
    chk("edge_busy", busy, 1);
    chk("edge_tmo", tmo, 0);
    step();
    chk("edge_done", done, 1);
    chk("edge_tmo2", tmo, 0);
    chk("edge_pass", pass, 0);
    go();
    wr(0, 1);
    chk("x0_busy_u1", busy1, 1);
    chk("x0_busy_u0", busy, 1);
    wr(26, 2);
    chk("val2_busy", busy, 1);
    retire_i = 1;
    repeat (10) step();
    retire_i = 0;
    chk("retire_cnt", rcnt, 10);
    chk("retire_busy", busy, 1);
    go();
    chk("ign_start_cycle", ccnt, 13);
    chk("ign_start_rcnt", rcnt, 10);
    wr(3, 4);
    wr(26, 1);
    step();
    chk("fail2_ftn", ftn, 4);
    go();
    chk("restart_busy", busy, 1);
    chk("restart_cycle", ccnt, 0);
    chk("restart_rcnt", rcnt, 0);
    chk("restart_ftn", ftn, 0);
    wr(3, 6);
    wr(26, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    step();
    rst = 0;
    chk("rst2_busy", busy, 0);
    chk("rst2_done", done, 0);
    chk("rst2_pass", pass, 0);
    chk("rst2_tmo", tmo, 0);
    chk("rst2_cycle", ccnt, 0);
    chk("rst2_rcnt", rcnt, 0);
    chk("rst2_ftn", ftn, 0);
    step();
    chk("rst2_hold_done", done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
